// File: rtl/dom_sqscmul_gf2_arbiter.sv
// Round-robin front end that time-shares one masked GF(2^2) square-scale-multiply
// unit, pairing each grant with one PRNG word and tagging results with the owner id.
module dom_sqscmul_gf2_arbiter #(
   parameter int NREQ        = 3,
   parameter int SHARES      = 2,
   parameter int BLIND_NRND  = 1,
   parameter int MUL_LATENCY = 1,
   parameter int ZERO_GAP    = 1
) (
   input  logic                                      ClkxCI,
   input  logic                                      RstxBI,
   input  logic [NREQ-1:0]                           ReqValidxSI,
   output logic [NREQ-1:0]                           ReqReadyxSO,
   input  logic [NREQ*2*SHARES-1:0]                  ReqXxDI,
   input  logic [NREQ*2*SHARES-1:0]                  ReqYxDI,
   input  logic                                      RndValidxSI,
   output logic                                      RndReadyxSO,
   input  logic [SHARES*(SHARES-1)+2*BLIND_NRND-1:0] RndxDI,
   output logic [2*SHARES-1:0]                       MulXxDO,
   output logic [2*SHARES-1:0]                       MulYxDO,
   output logic [SHARES*(SHARES-1)-1:0]              MulZxDO,
   output logic [2*BLIND_NRND-1:0]                   MulBxDO,
   input  logic [2*SHARES-1:0]                       MulQxDI,
   output logic                                      RspValidxSO,
   output logic [NREQ-1:0]                           RspIdxDO,
   output logic [2*SHARES-1:0]                       RspQxDO,
   output logic                                      BusyxSO
);

   localparam int EW  = 2 * SHARES;
   localparam int ZW  = SHARES * (SHARES - 1);
   localparam int BW  = 2 * BLIND_NRND;
   localparam int LAT = 1 + MUL_LATENCY;
   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {StReady, StGap} state_e;

   state_e                    state_q, state_d;
   logic [PW-1:0]             ptr_q, ptr_d;
   logic [PW-1:0]             grantIdx;
   logic [PW:0]               cand;
   logic                      found;
   logic                      issue;
   logic [NREQ-1:0]           grantOh;
   logic [EW-1:0]             mulX_q, mulX_d, mulY_q, mulY_d;
   logic [ZW-1:0]             mulZ_q, mulZ_d;
   logic [BW-1:0]             mulB_q, mulB_d;
   logic [LAT-1:0]            rspVld_q, rspVld_d;
   logic [LAT-1:0][NREQ-1:0]  rspId_q, rspId_d;

   // First valid requester at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      grantIdx = '0;
      found    = 1'b0;
      cand     = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(i);
         if (cand >= (PW+1)'(NREQ)) begin
            cand = cand - (PW+1)'(NREQ);
         end
         if (!found && ReqValidxSI[cand]) begin
            found    = 1'b1;
            grantIdx = cand[PW-1:0];
         end
      end
   end

   // Reset gates the handshake so every output reads 0 while RstxBI is low.
   assign issue       = RstxBI && (state_q == StReady) && found && RndValidxSI;
   assign grantOh     = issue ? (NREQ'(1) << grantIdx) : '0;
   assign ReqReadyxSO = grantOh;
   assign RndReadyxSO = issue;

   always_comb begin
      state_d = StReady;
      if (issue && (ZERO_GAP != 0)) begin
         state_d = StGap;
      end
      ptr_d = ptr_q;
      if (issue) begin
         ptr_d = (grantIdx == PW'(NREQ - 1)) ? '0 : grantIdx + PW'(1);
      end
      // Operands live for exactly one cycle; idle cycles drive zeros to limit leakage.
      mulX_d = '0;
      mulY_d = '0;
      mulZ_d = '0;
      mulB_d = '0;
      if (issue) begin
         mulX_d = ReqXxDI[grantIdx*EW +: EW];
         mulY_d = ReqYxDI[grantIdx*EW +: EW];
         mulZ_d = RndxDI[ZW-1:0];
         mulB_d = RndxDI[ZW +: BW];
      end
      rspVld_d    = '0;
      rspId_d     = '0;
      rspVld_d[0] = issue;
      rspId_d[0]  = grantOh;
      for (int i = 1; i < LAT; i++) begin
         rspVld_d[i] = rspVld_q[i-1];
         rspId_d[i]  = rspId_q[i-1];
      end
   end

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         state_q  <= StReady;
         ptr_q    <= '0;
         mulX_q   <= '0;
         mulY_q   <= '0;
         mulZ_q   <= '0;
         mulB_q   <= '0;
         rspVld_q <= '0;
         rspId_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         mulX_q   <= mulX_d;
         mulY_q   <= mulY_d;
         mulZ_q   <= mulZ_d;
         mulB_q   <= mulB_d;
         rspVld_q <= rspVld_d;
         rspId_q  <= rspId_d;
      end
   end

   assign MulXxDO     = mulX_q;
   assign MulYxDO     = mulY_q;
   assign MulZxDO     = mulZ_q;
   assign MulBxDO     = mulB_q;
   assign RspValidxSO = rspVld_q[LAT-1];
   assign RspIdxDO    = rspId_q[LAT-1];
   assign RspQxDO     = rspVld_q[LAT-1] ? MulQxDI : '0;
   assign BusyxSO     = (|rspVld_q) || (state_q == StGap);

endmodule

// File: tb/tb_dom_sqscmul_gf2_arbiter.sv
// Bench for dom_sqscmul_gf2_arbiter: one instance with the zero gap, one without,
// both driven by shared stimulus and compared against a cycle-level reference model.
module tb_dom_sqscmul_gf2_arbiter;

   localparam int NREQ = 3;
   localparam int ML   = 1;
   localparam int HIST = 4096;

   logic            clk = 1'b0;
   logic            rstN;
   logic [2:0]      reqValid;
   logic            rndValid;
   logic [11:0]     reqX, reqY;
   logic [3:0]      rnd, mulQ;

   logic [1:0][2:0] reqRdy, rspId;
   logic [1:0]      rndRdy, rspV, busy;
   logic [1:0][3:0] mulX, mulY, rspQ;
   logic [1:0][1:0] mulZ, mulB;

   int testsRun  = 0;
   int failCount = 0;
   int cyc       = 4;

   int         ptrM[2];
   bit         issuedAt[2][HIST];
   int         gAt[2][HIST];
   logic [3:0] xAt[2][HIST];
   logic [3:0] yAt[2][HIST];
   logic [3:0] rndAt[2][HIST];

   typedef struct {
      logic       rstN;
      logic [2:0] rv;
      logic       rndV;
      logic [3:0] rnd;
      logic [3:0] mulQ;
      logic [2:0] eReady;
      logic       eRnd;
      logic [3:0] eMulX;
      logic       eRspV;
      logic [2:0] eRspId;
      logic       eBusy;
   } vec_t;

   vec_t tbl[28];

   logic [2:0] nogapSeq[7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
   logic [2:0] gapSeq[7]   = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

   always #5 clk = ~clk;

   dom_sqscmul_gf2_arbiter #(.NREQ(3), .SHARES(2), .BLIND_NRND(1), .MUL_LATENCY(ML), .ZERO_GAP(1)) dutGap (
      .ClkxCI(clk), .RstxBI(rstN),
      .ReqValidxSI(reqValid), .ReqReadyxSO(reqRdy[0]),
      .ReqXxDI(reqX), .ReqYxDI(reqY),
      .RndValidxSI(rndValid), .RndReadyxSO(rndRdy[0]), .RndxDI(rnd),
      .MulXxDO(mulX[0]), .MulYxDO(mulY[0]), .MulZxDO(mulZ[0]), .MulBxDO(mulB[0]),
      .MulQxDI(mulQ),
      .RspValidxSO(rspV[0]), .RspIdxDO(rspId[0]), .RspQxDO(rspQ[0]),
      .BusyxSO(busy[0])
   );

   dom_sqscmul_gf2_arbiter #(.NREQ(3), .SHARES(2), .BLIND_NRND(1), .MUL_LATENCY(ML), .ZERO_GAP(0)) dutNoGap (
      .ClkxCI(clk), .RstxBI(rstN),
      .ReqValidxSI(reqValid), .ReqReadyxSO(reqRdy[1]),
      .ReqXxDI(reqX), .ReqYxDI(reqY),
      .RndValidxSI(rndValid), .RndReadyxSO(rndRdy[1]), .RndxDI(rnd),
      .MulXxDO(mulX[1]), .MulYxDO(mulY[1]), .MulZxDO(mulZ[1]), .MulBxDO(mulB[1]),
      .MulQxDI(mulQ),
      .RspValidxSO(rspV[1]), .RspIdxDO(rspId[1]), .RspQxDO(rspQ[1]),
      .BusyxSO(busy[1])
   );

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 1 ns later.
   task automatic applyStimulus(input logic r, input logic [2:0] rv, input logic rndV,
                                input logic [11:0] x, input logic [11:0] y,
                                input logic [3:0] rw, input logic [3:0] q);
      @(negedge clk);
      rstN     = r;
      reqValid = rv;
      rndValid = rndV;
      reqX     = x;
      reqY     = y;
      rnd      = rw;
      mulQ     = q;
      #1;
   endtask

   // Reference: handshake at t puts operands out at t+1 and the tagged result at t+1+ML;
   // the gapped instance refuses to issue in the cycle right after an issue.
   task automatic modelStep();
      for (int k = 0; k < 2; k++) begin
         logic [2:0] eReady, eRspId;
         logic       eRnd, eRspV, eBusy, gap, issue;
         logic [3:0] eMulX, eMulY, eRspQ;
         logic [1:0] eMulZ, eMulB;
         string      tag;
         int         g;
         eReady = '0; eRspId = '0; eRnd = 1'b0; eRspV = 1'b0; eBusy = 1'b0;
         eMulX = '0; eMulY = '0; eRspQ = '0; eMulZ = '0; eMulB = '0;
         g   = -1;
         tag = (k == 0) ? "gap" : "nogap";
         if (!rstN) begin
            for (int j = 0; j <= ML; j++) issuedAt[k][cyc-1-j] = 1'b0;
            issuedAt[k][cyc] = 1'b0;
            ptrM[k] = 0;
         end else begin
            gap = (k == 0) && issuedAt[k][cyc-1];
            for (int j = 0; j <= ML; j++) if (issuedAt[k][cyc-1-j]) eBusy = 1'b1;
            if (gap) eBusy = 1'b1;
            if (issuedAt[k][cyc-1]) begin
               eMulX = xAt[k][cyc-1];
               eMulY = yAt[k][cyc-1];
               eMulZ = rndAt[k][cyc-1][1:0];
               eMulB = rndAt[k][cyc-1][3:2];
            end
            if (issuedAt[k][cyc-1-ML]) begin
               eRspV  = 1'b1;
               eRspId = 3'(1 << gAt[k][cyc-1-ML]);
               eRspQ  = mulQ;
            end
            issue = !gap && (reqValid != 3'b000) && rndValid;
            issuedAt[k][cyc] = issue;
            if (issue) begin
               for (int j = 0; j < NREQ; j++)
                  if (g < 0 && reqValid[(ptrM[k] + j) % NREQ]) g = (ptrM[k] + j) % NREQ;
               eReady         = 3'(1 << g);
               eRnd           = 1'b1;
               ptrM[k]        = (g + 1) % NREQ;
               gAt[k][cyc]    = g;
               xAt[k][cyc]    = reqX[g*4 +: 4];
               yAt[k][cyc]    = reqY[g*4 +: 4];
               rndAt[k][cyc]  = rnd;
            end
         end
         checkOutput({tag, ".ReqReady"}, 32'(reqRdy[k]), 32'(eReady));
         checkOutput({tag, ".RndReady"}, 32'(rndRdy[k]), 32'(eRnd));
         checkOutput({tag, ".MulX"},     32'(mulX[k]),   32'(eMulX));
         checkOutput({tag, ".MulY"},     32'(mulY[k]),   32'(eMulY));
         checkOutput({tag, ".MulZ"},     32'(mulZ[k]),   32'(eMulZ));
         checkOutput({tag, ".MulB"},     32'(mulB[k]),   32'(eMulB));
         checkOutput({tag, ".RspValid"}, 32'(rspV[k]),   32'(eRspV));
         checkOutput({tag, ".RspId"},    32'(rspId[k]),  32'(eRspId));
         checkOutput({tag, ".RspQ"},     32'(rspQ[k]),   32'(eRspQ));
         checkOutput({tag, ".Busy"},     32'(busy[k]),   32'(eBusy));
      end
      cyc++;
   endtask

   initial begin
      rstN = 1'b0; reqValid = '0; rndValid = 1'b0;
      reqX = '0; reqY = '0; rnd = '0; mulQ = '0;

      // Requesters 0/1/2 carry X = 3/9/C and Y = 5/6/A; rows track the gapped instance.
      //              rst  rv      rndV  rnd    mulQ   ready   rndR  mulX   rspV  rspId   busy
      tbl[0]  = '{1'b0, 3'b111, 1'b1, 4'h0, 4'h5, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[1]  = '{1'b0, 3'b111, 1'b1, 4'h0, 4'h6, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[2]  = '{1'b1, 3'b010, 1'b1, 4'h1, 4'h7, 3'b010, 1'b1, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[3]  = '{1'b1, 3'b000, 1'b1, 4'h2, 4'h8, 3'b000, 1'b0, 4'h9, 1'b0, 3'b000, 1'b1};
      tbl[4]  = '{1'b1, 3'b000, 1'b1, 4'h3, 4'hB, 3'b000, 1'b0, 4'h0, 1'b1, 3'b010, 1'b1};
      tbl[5]  = '{1'b1, 3'b111, 1'b0, 4'h4, 4'hC, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[6]  = '{1'b1, 3'b111, 1'b0, 4'h5, 4'hD, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[7]  = '{1'b1, 3'b111, 1'b0, 4'h6, 4'hE, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[8]  = '{1'b1, 3'b111, 1'b1, 4'h7, 4'hF, 3'b100, 1'b1, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[9]  = '{1'b1, 3'b011, 1'b1, 4'h8, 4'h1, 3'b000, 1'b0, 4'hC, 1'b0, 3'b000, 1'b1};
      tbl[10] = '{1'b1, 3'b011, 1'b1, 4'h9, 4'h2, 3'b001, 1'b1, 4'h0, 1'b1, 3'b100, 1'b1};
      tbl[11] = '{1'b1, 3'b010, 1'b1, 4'hA, 4'h3, 3'b000, 1'b0, 4'h3, 1'b0, 3'b000, 1'b1};
      tbl[12] = '{1'b1, 3'b010, 1'b1, 4'hB, 4'h4, 3'b010, 1'b1, 4'h0, 1'b1, 3'b001, 1'b1};
      tbl[13] = '{1'b1, 3'b001, 1'b1, 4'hC, 4'h5, 3'b000, 1'b0, 4'h9, 1'b0, 3'b000, 1'b1};
      tbl[14] = '{1'b1, 3'b001, 1'b1, 4'hD, 4'h6, 3'b001, 1'b1, 4'h0, 1'b1, 3'b010, 1'b1};
      tbl[15] = '{1'b1, 3'b111, 1'b1, 4'hE, 4'h7, 3'b000, 1'b0, 4'h3, 1'b0, 3'b000, 1'b1};
      tbl[16] = '{1'b1, 3'b111, 1'b1, 4'hF, 4'h8, 3'b010, 1'b1, 4'h0, 1'b1, 3'b001, 1'b1};
      tbl[17] = '{1'b1, 3'b000, 1'b1, 4'h0, 4'h9, 3'b000, 1'b0, 4'h9, 1'b0, 3'b000, 1'b1};
      tbl[18] = '{1'b1, 3'b000, 1'b1, 4'h1, 4'hA, 3'b000, 1'b0, 4'h0, 1'b1, 3'b010, 1'b1};
      tbl[19] = '{1'b1, 3'b100, 1'b1, 4'h2, 4'hB, 3'b100, 1'b1, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[20] = '{1'b0, 3'b100, 1'b1, 4'h3, 4'hC, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[21] = '{1'b0, 3'b100, 1'b1, 4'h4, 4'hD, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[22] = '{1'b1, 3'b000, 1'b1, 4'h5, 4'hE, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[23] = '{1'b1, 3'b000, 1'b1, 4'h6, 4'hF, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[24] = '{1'b1, 3'b111, 1'b1, 4'h7, 4'h1, 3'b001, 1'b1, 4'h0, 1'b0, 3'b000, 1'b0};
      tbl[25] = '{1'b1, 3'b000, 1'b1, 4'h8, 4'h2, 3'b000, 1'b0, 4'h3, 1'b0, 3'b000, 1'b1};
      tbl[26] = '{1'b1, 3'b000, 1'b1, 4'h9, 4'h3, 3'b000, 1'b0, 4'h0, 1'b1, 3'b001, 1'b1};
      tbl[27] = '{1'b1, 3'b000, 1'b1, 4'hA, 4'h4, 3'b000, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0};

      for (int i = 0; i < 28; i++) begin
         applyStimulus(tbl[i].rstN, tbl[i].rv, tbl[i].rndV, 12'hC93, 12'hA65, tbl[i].rnd, tbl[i].mulQ);
         modelStep();
         checkOutput("tbl.ReqReady", 32'(reqRdy[0]), 32'(tbl[i].eReady));
         checkOutput("tbl.RndReady", 32'(rndRdy[0]), 32'(tbl[i].eRnd));
         checkOutput("tbl.MulX",     32'(mulX[0]),   32'(tbl[i].eMulX));
         checkOutput("tbl.RspValid", 32'(rspV[0]),   32'(tbl[i].eRspV));
         checkOutput("tbl.RspId",    32'(rspId[0]),  32'(tbl[i].eRspId));
         checkOutput("tbl.RspQ",     32'(rspQ[0]),   tbl[i].eRspV ? 32'(tbl[i].mulQ) : 32'h0);
         checkOutput("tbl.Busy",     32'(busy[0]),   32'(tbl[i].eBusy));
      end

      // All requesters valid from a fresh reset: back-to-back grants versus every other cycle.
      applyStimulus(1'b0, 3'b000, 1'b0, 12'hC93, 12'hA65, 4'h0, 4'h0);
      modelStep();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 3'b111, 1'b1, 12'hC93, 12'hA65, 4'(i), 4'(i + 3));
         modelStep();
         checkOutput("seq.nogap.ReqReady", 32'(reqRdy[1]), 32'(nogapSeq[i]));
         checkOutput("seq.gap.ReqReady",   32'(reqRdy[0]), 32'(gapSeq[i]));
         checkOutput("seq.nogap.RspValid", 32'(rspV[1]),   (i >= 2) ? 32'h1 : 32'h0);
         if (i >= 2) checkOutput("seq.nogap.RspId", 32'(rspId[1]), 32'(nogapSeq[i-2]));
      end

      // Random traffic with occasional resets, checked only by the reference model.
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(($urandom_range(0, 63) != 0), 3'($urandom), ($urandom_range(0, 3) != 0),
                       12'($urandom), 12'($urandom), 4'($urandom), 4'($urandom));
         modelStep();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
